reg_cmd_master: RTL

REG_CMD_MASTER -- requirements
Module: reg_cmd_master

---
 rtl/reg_pkg.sv | 11 +
 rtl/reg_cmd_fifo.sv | 39 +++
 rtl/reg_cmd_master.sv | 121 ++++++++++++
 3 files changed

// File: rtl/reg_pkg.sv
// reg_pkg: shared widths, command record and FSM state encoding for the register command master
package reg_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
endpackage

// File: rtl/reg_cmd_fifo.sv
// reg_cmd_fifo: power-of-two command queue; pushes into a full queue and pops from an empty one are ignored
module reg_cmd_fifo import reg_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   din,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign dout    = mem[rp];
  // storage is not reset; only the pointers define validity
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/reg_cmd_master.sv
// reg_cmd_master: queues register commands and plays them onto a sel/ready bus with timeout and read responses
module reg_cmd_master #(
  parameter int ADDR_WIDTH = reg_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = reg_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  sel,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  err_pulse,
  output logic                  busy
);
  import reg_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, rsp_data_n;
  logic sel_n, wr_n, rsp_valid_n, rsp_err_n, err_pulse_n;
  logic pop, full, empty;
  logic [$clog2(FIFO_DEPTH):0] level;
  cmd_t din, head;
  assign cmd_ready = !full;
  assign din       = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
  assign busy      = (state != IDLE) || (level != '0);
  reg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(cmd_valid && cmd_ready), .pop(pop),
    .din(din), .dout(head), .full(full), .empty(empty), .level(level)
  );
  // next-state and next bus/response values; a read never issues while a response is still unconsumed
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr;
    sel_n       = sel;
    wr_n        = wr;
    wdata_n     = wdata;
    rsp_valid_n = rsp_valid && !rsp_ready;
    rsp_err_n   = rsp_err;
    rsp_data_n  = rsp_data;
    err_pulse_n = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE:
        if (!empty && (head.wr || !rsp_valid)) begin
          pop     = 1'b1;
          addr_n  = head.addr;
          wr_n    = head.wr;
          wdata_n = head.wdata;
          sel_n   = 1'b1;
          cnt_n   = '0;
          state_n = ISSUE;
        end
      ISSUE:
        if (ready) begin
          sel_n   = !wr;
          wr_n    = 1'b0;
          state_n = wr ? IDLE : RD_WAIT;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          sel_n       = 1'b0;
          wr_n        = 1'b0;
          err_pulse_n = 1'b1;
          state_n     = IDLE;
          if (!wr) begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_data_n  = '0;
          end
        end else
          cnt_n = cnt + 1'b1;
      RD_WAIT: begin
        rsp_data_n  = rdata;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b0;
        sel_n       = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, bus and response registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      sel       <= 1'b0;
      wr        <= 1'b0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      sel       <= sel_n;
      wr        <= wr_n;
      wdata     <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_data  <= rsp_data_n;
      err_pulse <= err_pulse_n;
    end
endmodule
